// File: rtl/print_decimal_pkg.sv
// Shared constants, segment table and FSM state type for the decimal display driver.
package print_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Entries 10-15 are unreachable BCD codes and map to blank.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/print_decimal_seg7_encode.sv
// Combinational BCD digit to active-low {g..a} segment pattern.
module seg7_encode
  import print_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_digit];

endmodule

// File: rtl/print_decimal.sv
// Iterative double-dabble binary-to-decimal converter driving a bank of registered 7-segment digits.
module print_decimal
  import print_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6,
  parameter int SIGNED = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_load,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_hex
);

  localparam int          CW       = $clog2(WIDTH);
  localparam int          BW       = 4 * DIGITS;
  localparam logic [63:0] MAX_MAG  = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] MIN_FULL = pow10(DIGITS - 1);

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [WIDTH-1:0]      r_mag;
  logic [BW-1:0]         r_bcd;
  logic                  r_neg, r_ovf;
  logic                  r_ready, r_done, r_overflow;
  logic [7*DIGITS-1:0]   r_hex;

  logic                  w_neg, w_ovf;
  logic [WIDTH-1:0]      w_mag;
  logic [63:0]           w_mag64;
  logic [BW-1:0]         w_bcd_adj, w_bcd_shift;
  logic [3:0]            w_msd;
  logic [6:0]            w_seg [DIGITS];
  logic [7*DIGITS-1:0]   w_hex;

  // Magnitude is taken as an unsigned WIDTH-bit quantity so the most negative value does not wrap.
  assign w_neg   = (SIGNED != 0) && i_value[WIDTH-1];
  assign w_mag   = w_neg ? (~i_value + {{(WIDTH-1){1'b0}}, 1'b1}) : i_value;
  assign w_mag64 = 64'(w_mag);
  assign w_ovf   = (w_mag64 > MAX_MAG) || (w_neg && (w_mag64 >= MIN_FULL));

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_load) w_next = SHIFT; else w_next = IDLE;
      SHIFT:   if (r_cnt == {CW{1'b0}}) w_next = EMIT; else w_next = SHIFT;
      EMIT:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Add-3 correction on every nibble, then shift in the next magnitude bit.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end else begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4];
      end
    end
  end

  assign w_bcd_shift = {w_bcd_adj[BW-2:0], r_mag[WIDTH-1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .i_digit (r_bcd[4*g +: 4]),
      .o_seg   (w_seg[g])
    );
  end

  // Blanking, sign placement and overflow substitution per digit.
  always_comb begin
    w_msd = 4'd0;
    w_hex = {(7*DIGITS){1'b1}};
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] != 4'd0) w_msd = 4'(k); else w_msd = w_msd;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (r_ovf) begin
        w_hex[7*k +: 7] = SEG_MINUS;
      end else if (4'(k) <= w_msd) begin
        w_hex[7*k +: 7] = w_seg[k];
      end else if (r_neg && (4'(k) == w_msd + 4'd1)) begin
        w_hex[7*k +: 7] = SEG_MINUS;
      end else begin
        w_hex[7*k +: 7] = SEG_BLANK;
      end
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= {CW{1'b0}};
      r_mag      <= {WIDTH{1'b0}};
      r_bcd      <= {BW{1'b0}};
      r_neg      <= 1'b0;
      r_ovf      <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_hex      <= {(7*DIGITS){1'b1}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_mag   <= w_mag;
            r_neg   <= w_neg;
            r_ovf   <= w_ovf;
            r_bcd   <= {BW{1'b0}};
            r_cnt   <= CW'(WIDTH - 1);
            r_ready <= 1'b0;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_shift;
          r_mag <= {r_mag[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end
        EMIT: begin
          r_hex      <= w_hex;
          r_overflow <= r_ovf;
          r_done     <= 1'b1;
          r_ready    <= 1'b1;
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_hex      = r_hex;

endmodule

// File: tb/tb_print_decimal.sv
// Self-checking bench: unsigned and signed instances against an arithmetic digit model.
module tb_print_decimal;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] val_u, val_s;
  logic        load_u, load_s;
  logic        ready_u, done_u, ovf_u, ready_s, done_s, ovf_s;
  logic [41:0] hex_u, hex_s;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  print_decimal #(.WIDTH(20), .DIGITS(6), .SIGNED(0)) dut_u (
    .i_clk(clk), .i_rst(rst), .i_value(val_u), .i_load(load_u),
    .o_ready(ready_u), .o_done(done_u), .o_overflow(ovf_u), .o_hex(hex_u)
  );

  print_decimal #(.WIDTH(20), .DIGITS(6), .SIGNED(1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_value(val_s), .i_load(load_s),
    .o_ready(ready_s), .o_done(done_s), .o_overflow(ovf_s), .o_hex(hex_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input longint d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1011000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Returns {overflow, hex} for a 20-bit value on a 6-digit display.
  function automatic logic [42:0] model(input logic [19:0] v, input bit sgn);
    bit          neg, ovf;
    longint      mag, t, pw;
    int          nd;
    logic [41:0] h;
    neg = sgn && v[19];
    mag = neg ? (longint'(1048576) - longint'(v)) : longint'(v);
    nd = 1;
    t = mag;
    while (t >= 10) begin
      t = t / 10;
      nd++;
    end
    ovf = (mag > 999999) || (neg && nd == 6);
    pw = 1;
    for (int k = 0; k < 6; k++) begin
      if (ovf)                 h[7*k +: 7] = 7'b0111111;
      else if (k < nd)         h[7*k +: 7] = seg_of((mag / pw) % 10);
      else if (neg && k == nd) h[7*k +: 7] = 7'b0111111;
      else                     h[7*k +: 7] = 7'b1111111;
      pw = pw * 10;
    end
    return {ovf, h};
  endfunction

  task automatic convert(input bit sgn, input logic [19:0] v, input string tag);
    logic [42:0] exp;
    int          cyc;
    exp = model(v, sgn);
    @(negedge clk);
    if (sgn) begin val_s = v; load_s = 1'b1; end
    else     begin val_u = v; load_u = 1'b1; end
    check({tag, "_ready_before"}, 64'(sgn ? ready_s : ready_u), 64'd1);
    @(posedge clk); #1;
    load_s = 1'b0;
    load_u = 1'b0;
    cyc = 0;
    while (((sgn ? done_s : done_u) !== 1'b1) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd21);
    check({tag, "_hex"}, 64'(sgn ? hex_s : hex_u), 64'(exp[41:0]));
    check({tag, "_ovf"}, 64'(sgn ? ovf_s : ovf_u), 64'(exp[42]));
    @(posedge clk); #1;
    check({tag, "_ready_after"}, 64'(sgn ? ready_s : ready_u), 64'd1);
    check({tag, "_done_pulse"}, 64'(sgn ? done_s : done_u), 64'd0);
  endtask

  initial begin
    int          cyc, ndone;
    logic [19:0] rv;
    logic [42:0] e55;
    rst = 1'b1; load_u = 1'b0; load_s = 1'b0; val_u = 20'd0; val_s = 20'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hex", 64'(hex_u), 64'h3FFFFFFFFFF);
    check("rst_ready", 64'(ready_u), 64'd1);
    check("rst_done", 64'(done_u), 64'd0);
    check("rst_ovf", 64'(ovf_u), 64'd0);
    @(negedge clk) rst = 1'b0;

    convert(1'b0, 20'd0, "zero");
    convert(1'b0, 20'd123456, "v123456");
    convert(1'b0, 20'd7, "v7");
    convert(1'b0, 20'd1000000, "v1000000");
    convert(1'b0, 20'd999999, "v999999");
    convert(1'b0, 20'hFFFFF, "vmax");
    convert(1'b1, 20'(-42), "s_m42");
    convert(1'b1, 20'h80000, "s_mostneg");
    convert(1'b1, 20'(-99999), "s_m99999");
    convert(1'b1, 20'(-100000), "s_m100000");
    convert(1'b1, 20'd524287, "s_maxpos");
    for (int i = 0; i < 12; i++) begin
      rv = 20'($urandom);
      if (i % 3 == 0) rv = 20'($urandom_range(0, 999));
      convert(1'b0, rv, "rand_u");
      rv = 20'($urandom);
      if (i % 3 == 1) rv = 20'(-$urandom_range(1, 9999));
      convert(1'b1, rv, "rand_s");
    end

    // Loads presented while busy must be ignored, not queued.
    e55 = model(20'd55, 1'b0);
    @(negedge clk);
    val_u = 20'd55; load_u = 1'b1;
    @(posedge clk); #1;
    val_u = 20'd77;
    cyc = 0;
    while (done_u !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    load_u = 1'b0;
    check("busy_latency", 64'(cyc), 64'd21);
    check("busy_hex", 64'(hex_u), 64'(e55[41:0]));
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_u === 1'b1) ndone++;
    end
    check("busy_no_queue", 64'(ndone), 64'd0);

    // Reset in the middle of a shift sequence.
    @(negedge clk);
    val_u = 20'd4321; load_u = 1'b1;
    @(posedge clk); #1;
    load_u = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_hex", 64'(hex_u), 64'h3FFFFFFFFFF);
    check("midrst_ready", 64'(ready_u), 64'd1);
    check("midrst_done", 64'(done_u), 64'd0);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_u === 1'b1) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    convert(1'b0, 20'd808, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
